// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the RISC-V core: result source, ALU control,
// the packed decode-to-execute control word and its all-zero NOP value.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef logic [2:0] alu_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_t   alu_ctrl;
    logic        alu_src;
  } de_ctrl_t;

  localparam de_ctrl_t DE_CTRL_NOP = '0;

endpackage

// File: rtl/wb_bypass.sv
// Writeback-to-decode bypass for one register-file read port. Covers the
// gap between the register file writing at the clock edge and reading
// combinationally: when Writeback targets the register being read, the new
// data is forwarded instead of the stale read value. x0 is never forwarded.
module wb_bypass
  import riscv_pipe_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]    rd_raw,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0]    wd,
  output logic [DATA_WIDTH-1:0]    rd_fwd
);

  // Select the writeback data on an index match to a non-zero register.
  always_comb begin
    rd_fwd = rd_raw;
    if (we && (a3 == rs) && (a3 != '0)) begin
      rd_fwd = wd;
    end
  end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register.
// Optional feature macro: DE_WB_BYPASS_EN (writeback-to-decode bypass on
// RD1/RD2). Without it the raw register-file values are captured.
//
// Valid semantics: valid_d marks a real instruction in Decode. There is no
// ready; back-pressure is stall_i (hold) and cancellation is flush_i
// (bubble). Edge priority is rst > flush_i > stall_i > load, and a load with
// valid_d=0 produces a bubble.
module decode_execute_reg
  import riscv_pipe_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     valid_d,
  input  logic [DATA_WIDTH-1:0]    rd1_d,
  input  logic [DATA_WIDTH-1:0]    rd2_d,
  input  logic [ADDRESS_WIDTH-1:0] rs1_d,
  input  logic [ADDRESS_WIDTH-1:0] rs2_d,
  input  logic [ADDRESS_WIDTH-1:0] rd_d,
  input  logic [DATA_WIDTH-1:0]    pc_d,
  input  logic [DATA_WIDTH-1:0]    pc_plus4_d,
  input  logic [DATA_WIDTH-1:0]    imm_d,
  input  de_ctrl_t                 ctrl_d,
  input  logic                     we3_w,
  input  logic [ADDRESS_WIDTH-1:0] a3_w,
  input  logic [DATA_WIDTH-1:0]    wd3_w,
  output logic                     valid_e,
  output logic [DATA_WIDTH-1:0]    rd1_e,
  output logic [DATA_WIDTH-1:0]    rd2_e,
  output logic [ADDRESS_WIDTH-1:0] rs1_e,
  output logic [ADDRESS_WIDTH-1:0] rs2_e,
  output logic [ADDRESS_WIDTH-1:0] rd_e,
  output logic [DATA_WIDTH-1:0]    pc_e,
  output logic [DATA_WIDTH-1:0]    pc_plus4_e,
  output logic [DATA_WIDTH-1:0]    imm_e,
  output de_ctrl_t                 ctrl_e,
  output logic                     load_use_o
);

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    pc_plus4;
    logic [DATA_WIDTH-1:0]    imm;
    de_ctrl_t                 ctrl;
  } e_stage_t;

  e_stage_t               e_d;
  e_stage_t               e_q;
  logic [DATA_WIDTH-1:0]  rd1_fwd;
  logic [DATA_WIDTH-1:0]  rd2_fwd;

`ifdef DE_WB_BYPASS_EN
  wb_bypass #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_bypass_rs1 (
    .rs    (rs1_d),
    .rd_raw(rd1_d),
    .we    (we3_w),
    .a3    (a3_w),
    .wd    (wd3_w),
    .rd_fwd(rd1_fwd)
  );

  wb_bypass #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_bypass_rs2 (
    .rs    (rs2_d),
    .rd_raw(rd2_d),
    .we    (we3_w),
    .a3    (a3_w),
    .wd    (wd3_w),
    .rd_fwd(rd2_fwd)
  );
`else
  // Writeback port is not consumed without the bypass; the hazard unit
  // covers W-to-D dependencies with an extra stall cycle instead.
  logic unused_wb_port;
  assign unused_wb_port = ^{we3_w, a3_w, wd3_w};
  assign rd1_fwd = rd1_d;
  assign rd2_fwd = rd2_d;
`endif

  // Next E-stage contents: flush beats stall, stall holds, invalid D loads a bubble.
  always_comb begin
    e_d = e_q;
    if (flush_i) begin
      e_d = '0;
    end else if (stall_i) begin
      e_d = e_q;
    end else if (!valid_d) begin
      e_d = '0;
    end else begin
      e_d.valid    = 1'b1;
      e_d.rd1      = rd1_fwd;
      e_d.rd2      = rd2_fwd;
      e_d.rs1      = rs1_d;
      e_d.rs2      = rs2_d;
      e_d.rd       = rd_d;
      e_d.pc       = pc_d;
      e_d.pc_plus4 = pc_plus4_d;
      e_d.imm      = imm_d;
      e_d.ctrl     = ctrl_d;
    end
  end

  // E-stage register with asynchronous clear to an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  // Load-use request: a valid load in E writes a register Decode is reading.
  // Depends only on E state and D source indices, never on stall/flush.
  always_comb begin
    load_use_o = e_q.valid
              && (e_q.ctrl.result_src == RES_MEM)
              && (e_q.rd != '0)
              && ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
  end

  assign valid_e    = e_q.valid;
  assign rd1_e      = e_q.rd1;
  assign rd2_e      = e_q.rd2;
  assign rs1_e      = e_q.rs1;
  assign rs2_e      = e_q.rs2;
  assign rd_e       = e_q.rd;
  assign pc_e       = e_q.pc;
  assign pc_plus4_e = e_q.pc_plus4;
  assign imm_e      = e_q.imm;
  assign ctrl_e     = e_q.ctrl;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: directed steps from the test plan followed by
// randomized traffic, checked against a record-level model of the E stage.
// Honors DE_WB_BYPASS_EN the same way the design does.
module tb_decode_execute_reg;
  import riscv_pipe_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 1 + 5 * DW + 3 * AW + 10;

`ifdef DE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          stall_i, flush_i, valid_d;
  logic [DW-1:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_d, wd3_w;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, a3_w;
  de_ctrl_t      ctrl_d;
  logic          we3_w;
  logic          valid_e;
  logic [DW-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_e;
  logic [AW-1:0] rs1_e, rs2_e, rd_e;
  de_ctrl_t      ctrl_e;
  logic          load_use_o;

  decode_execute_reg #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd_d(rd_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .imm_d(imm_d), .ctrl_d(ctrl_d), .we3_w(we3_w), .a3_w(a3_w),
    .wd3_w(wd3_w), .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .imm_e(imm_e), .ctrl_e(ctrl_e),
    .load_use_o(load_use_o)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rd1, rd2;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] pc, pc4, imm;
    logic [9:0]    ctrl;
  } model_t;

  model_t        m;
  logic [SW-1:0] exp_q[$];
  int            total = 0;
  int            bad   = 0;

  function automatic logic [DW-1:0] read_port(logic [AW-1:0] rs, logic [DW-1:0] raw);
    if (BYP && we3_w && (a3_w == rs) && (a3_w != 0)) return wd3_w;
    return raw;
  endfunction

  // What the hazard unit should see: valid load in E writing a register D reads.
  function automatic logic exp_load_use();
    return m.valid && (m.ctrl[8:7] == 2'b01) && (m.rd != 0)
        && ((m.rd == rs1_d) || (m.rd == rs2_d));
  endfunction

  // Apply one clock edge to the model using the current D-side inputs.
  task automatic model_edge();
    model_t nxt;
    nxt = m;
    if (flush_i)       nxt = '0;
    else if (stall_i)  nxt = m;
    else if (!valid_d) nxt = '0;
    else begin
      nxt.valid = 1'b1;
      nxt.rd1   = read_port(rs1_d, rd1_d);
      nxt.rd2   = read_port(rs2_d, rd2_d);
      nxt.rs1   = rs1_d;
      nxt.rs2   = rs2_d;
      nxt.rd    = rd_d;
      nxt.pc    = pc_d;
      nxt.pc4   = pc_plus4_d;
      nxt.imm   = imm_d;
      nxt.ctrl  = ctrl_d;
    end
    exp_q.push_back(nxt);
  endtask

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".valid_e"},    DW'(valid_e),      DW'(m.valid));
    check({tag, ".rd1_e"},      rd1_e,             m.rd1);
    check({tag, ".rd2_e"},      rd2_e,             m.rd2);
    check({tag, ".rs1_e"},      DW'(rs1_e),        DW'(m.rs1));
    check({tag, ".rs2_e"},      DW'(rs2_e),        DW'(m.rs2));
    check({tag, ".rd_e"},       DW'(rd_e),         DW'(m.rd));
    check({tag, ".pc_e"},       pc_e,              m.pc);
    check({tag, ".pc_plus4_e"}, pc_plus4_e,        m.pc4);
    check({tag, ".imm_e"},      imm_e,             m.imm);
    check({tag, ".ctrl_e"},     DW'(ctrl_e),       DW'(m.ctrl));
    check({tag, ".load_use_o"}, DW'(load_use_o),   DW'(exp_load_use()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    stall_i = 0; flush_i = 0; valid_d = 0;
    rd1_d = 0; rd2_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
    pc_d = 0; pc_plus4_d = 0; imm_d = 0; ctrl_d = DE_CTRL_NOP;
    we3_w = 0; a3_w = 0; wd3_w = 0;
  endtask

  // One clock: model predicts, DUT clocks, outputs sampled 1 time unit later.
  task automatic tick(string tag);
    model_edge();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      m = exp_q.pop_front();
      check_all(tag);
    end
  endtask

  task automatic load_insn(logic [AW-1:0] rd, logic [1:0] res_src);
    valid_d = 1; rd_d = rd; ctrl_d = DE_CTRL_NOP;
    ctrl_d.reg_write = 1; ctrl_d.result_src = result_src_t'(res_src);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] cbits;
    m = '0;
    idle_inputs();
    rst = 1;
    #1;
    check_all("reset_initial");
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // Normal load
    load_insn(5'd3, 2'b00);
    rd1_d = 32'h11; imm_d = 32'h4; pc_d = 32'h40; pc_plus4_d = 32'h44;
    tick("normal_load");

    // Stall then flush+stall together
    pc_d = 32'h100; pc_plus4_d = 32'h104;
    tick("load_pc100");
    stall_i = 1; pc_d = 32'h104; pc_plus4_d = 32'h108;
    tick("stall_1");
    tick("stall_2");
    check("stall_pc_hold", pc_e, 32'h100);
    flush_i = 1;
    tick("flush_and_stall");
    check("flush_ctrl_zero", DW'(ctrl_e), 32'h0);
    stall_i = 0; flush_i = 0;

    // Bypass hit on rs1 and on rs2
    load_insn(5'd9, 2'b00);
    rs1_d = 5; rd1_d = 32'hDEAD; we3_w = 1; a3_w = 5; wd3_w = 32'hBEEF;
    rs2_d = 6; rd2_d = 32'h1234;
    tick("bypass_rs1");
    check("bypass_rd1_value", rd1_e, BYP ? 32'hBEEF : 32'hDEAD);
    rs1_d = 4; rs2_d = 5; rd2_d = 32'hCAFE;
    tick("bypass_rs2");
    // Writeback to x0 must never forward
    a3_w = 0; rs1_d = 0; rd1_d = 0; rs2_d = 0; rd2_d = 0; wd3_w = 32'h5555;
    tick("bypass_x0");
    check("bypass_x0_rd1", rd1_e, 32'h0);
    // Writeback disabled: no forwarding even on index match
    we3_w = 0; a3_w = 5; rs1_d = 5; rd1_d = 32'hDEAD; wd3_w = 32'hBEEF;
    tick("bypass_we_off");
    we3_w = 0; a3_w = 0; wd3_w = 0;

    // valid_d=0 during a normal load gives a bubble
    valid_d = 0;
    tick("invalid_d_bubble");

    // Load-use hazard
    load_insn(5'd7, 2'b01);
    rs1_d = 1; rs2_d = 2;
    tick("load_rd7");
    rs2_d = 7; #1;
    check("load_use_rs2_hit", DW'(load_use_o), 32'h1);
    rs2_d = 2; rs1_d = 7; #1;
    check("load_use_rs1_hit", DW'(load_use_o), 32'h1);
    rs1_d = 3; #1;
    check("load_use_no_match", DW'(load_use_o), 32'h0);
    load_insn(5'd0, 2'b01);
    rs1_d = 0; rs2_d = 0;
    tick("load_rd0");
    check("load_use_rd0", DW'(load_use_o), 32'h0);
    load_insn(5'd7, 2'b01);
    tick("load_rd7_again");
    rs2_d = 7; #1;
    check("load_use_before_flush", DW'(load_use_o), 32'h1);
    // stall must not mask the request
    stall_i = 1; #1;
    check("load_use_during_stall", DW'(load_use_o), 32'h1);
    stall_i = 0;
    flush_i = 1;
    tick("flush_load");
    check("load_use_after_flush", DW'(load_use_o), 32'h0);
    flush_i = 0;
    // Non-load in E with matching rd must not flag
    load_insn(5'd7, 2'b00);
    tick("alu_rd7");
    check("load_use_alu", DW'(load_use_o), 32'h0);

    // Randomized traffic with small index range to stress matches
    for (int i = 0; i < 300; i++) begin
      valid_d    = ($urandom_range(0, 9) != 0);
      stall_i    = ($urandom_range(0, 5) == 0);
      flush_i    = ($urandom_range(0, 7) == 0);
      rs1_d      = AW'($urandom_range(0, 7));
      rs2_d      = AW'($urandom_range(0, 7));
      rd_d       = AW'($urandom_range(0, 7));
      a3_w       = AW'($urandom_range(0, 7));
      we3_w      = $urandom_range(0, 1) != 0;
      rd1_d      = $urandom;
      rd2_d      = $urandom;
      wd3_w      = $urandom;
      pc_d       = $urandom;
      pc_plus4_d = pc_d + 32'd4;
      imm_d      = $urandom;
      cbits      = 10'($urandom);
      ctrl_d     = cbits;
      #1;
      check("rand_load_use_comb", DW'(load_use_o), DW'(exp_load_use()));
      tick("rand");
    end

    // Reset mid-cycle while E holds a valid instruction
    idle_inputs();
    load_insn(5'd3, 2'b01);
    rd1_d = 32'h77; pc_d = 32'h200;
    tick("pre_reset_load");
    rs1_d = 3; #2;
    rst = 1;
    m = '0;
    exp_q.delete();
    #1;
    check_all("reset_async");
    @(negedge clk);
    rst = 0;
    pc_d = 32'h300; rd1_d = 32'h88; rs1_d = 1;
    tick("post_reset_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_execute_reg.md
# decode_execute_reg

Decode-to-execute pipeline register for the pipelined RISC-V core. It captures the register-file read data, the immediate, the PC values and the decoded control word from the Decode stage, and presents them to Execute one cycle later. It supports stall, flush/bubble insertion, a writeback-to-decode same-cycle bypass that covers the register file's write-at-edge/read-combinational gap, and a load-use hazard flag for the hazard unit.

## Interface

Parameters:
- ADDRESS_WIDTH, 5: register index width.
- DATA_WIDTH, 32: datapath width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold all E-side registers.
- flush_i  in  1  load a bubble into E.
- valid_d  in  1  a valid instruction is present in Decode.
- rd1_d, rd2_d  in  DATA_WIDTH  register-file RD1/RD2.
- rs1_d, rs2_d, rd_d  in  ADDRESS_WIDTH  source and destination indices.
- pc_d, pc_plus4_d, imm_d  in  DATA_WIDTH  PC, PC+4, extended immediate.
- ctrl_d  in  de_ctrl_t  reg_write, result_src[1:0], mem_write, jump, branch, alu_ctrl[2:0], alu_src.
- we3_w  in  1  Writeback write enable (same signal as the register file's WE3).
- a3_w  in  ADDRESS_WIDTH  Writeback destination.
- wd3_w  in  DATA_WIDTH  Writeback data.
- valid_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e, imm_e, ctrl_e  out  (widths as D side)  registered Execute-side copies.
- load_use_o  out  1  combinational load-use hazard request.

## Operation

- Priority at each clock edge: rst > flush_i > stall_i > normal load.
- Normal load: every `_d` input is copied to the matching `_e` register. rd1_e and rd2_e receive the bypassed value when the bypass is enabled (see Configuration).
- Flush: valid_e=0 and every ctrl_e field=0, so reg_write, mem_write, jump and branch are all 0. rd_e=0. Data fields are cleared to 0.
- Stall: all `_e` registers hold their value.
- flush_i and stall_i asserted together: the flush wins and a bubble is inserted.
- valid_d=0 during a normal load: the stage loads as if flushed, giving a bubble.
- load_use_o=1 when all of the following hold:
  - valid_e=1,
  - ctrl_e.result_src==RES_MEM,
  - rd_e!=0,
  - rd_e==rs1_d or rd_e==rs2_d.
- An external hazard unit uses load_use_o to assert stall on F/D and flush on this stage.
- Index 0 is never bypassed or flagged; x0 always reads as 0.

## Timing

- Latency is 1 cycle, D to E. All `_e` outputs are registered.
- load_use_o is purely combinational from the E registers and rs1_d/rs2_d. It has no dependency on stall_i or flush_i, so it cannot form a combinational loop.
- Reset: every output is 0 asynchronously (valid_e=0, ctrl_e=0, all data and index fields 0, load_use_o=0).
- Reset mid-stall or mid-flush: the state returns to all-zero immediately. The first edge after rst deasserts loads normally.
- Bypass path: we3_w/a3_w/wd3_w feed the same edge at which the register file commits WD3. The E register therefore captures the new value in the same edge.

## Configuration

- Macro `DE_WB_BYPASS_EN`.
- Defined:
  - rd1_e captures wd3_w when we3_w && a3_w==rs1_d && a3_w!=0; otherwise it captures rd1_d.
  - rd2_e follows the same rule with rs2_d.
- Undefined:
  - rd1_e and rd2_e capture rd1_d and rd2_d unmodified.
  - The hazard unit must then stall one extra cycle on a W-to-D dependency.

## Structure

- Shared package riscv_pipe_pkg holds:
  - result_src_t: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - alu_ctrl_t, 3 bits.
  - packed struct de_ctrl_t.
  - localparam DE_CTRL_NOP, all zero.
- One sub-module, wb_bypass, handles a single read port: inputs rs, rd_raw, we, a3, wd; output rd_fwd. It is instantiated twice inside the `DE_WB_BYPASS_EN` guard.

## Test plan

- Reset: assert rst mid-cycle with valid_e=1 -> all outputs 0 immediately, without waiting for clk.
- Normal load: valid_d=1, rd1_d=32'h11, imm_d=32'h4, ctrl_d.reg_write=1 -> next edge gives valid_e=1, rd1_e=32'h11, imm_e=32'h4, ctrl_e.reg_write=1.
- Stall then flush: load pc_d=32'h100, then hold stall_i=1 for 2 cycles while pc_d=32'h104 -> pc_e stays 32'h100. Then flush_i=1 and stall_i=1 together -> valid_e=0 and ctrl_e=0.
- Bypass with macro defined: rs1_d=5, rd1_d=32'hDEAD, we3_w=1, a3_w=5, wd3_w=32'hBEEF -> rd1_e=32'hBEEF.
- Bypass exclusions: with a3_w=0, rs1_d=0, rd1_d=0 -> rd1_e=0. With the macro undefined -> rd1_e=32'hDEAD.
- Load-use: E holds a load with rd_e=7 and valid_e=1, and rs2_d=7 -> load_use_o=1. Changing rd_e to 0 or setting valid_e=0 -> load_use_o=0.
